// File: rtl/core_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, datapath width.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    FENCE  = 7'b0001111,
    SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Assemble the sign-extended immediate for the given encoding format.
  function automatic logic [XLEN-1:0] build_imm(imm_fmt_e fmt, logic [31:0] instr);
    case (fmt)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/core_decoder.sv
// Combinational RV32 instruction decoder: source usage, write enable, immediate.
module core_decoder
  import core_pkg::*;
(
  input  logic [31:0]     i_instr,
  output logic            o_rs1_used,
  output logic            o_rs2_used,
  output logic            o_wreg,
  output logic            o_is_load,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd
);

  logic     w_writes;
  imm_fmt_e w_fmt;

  // Classify the opcode into source usage, rd write and immediate format.
  always_comb begin
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    o_is_load  = 1'b0;
    o_illegal  = 1'b0;
    w_writes   = 1'b0;
    w_fmt      = IMM_NONE;
    case (i_instr[6:0])
      LUI, AUIPC: begin
        w_writes = 1'b1;
        w_fmt    = IMM_U;
      end
      JAL: begin
        w_writes = 1'b1;
        w_fmt    = IMM_J;
      end
      JALR, OP_IMM: begin
        o_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_fmt      = IMM_I;
      end
      LOAD: begin
        o_rs1_used = 1'b1;
        o_is_load  = 1'b1;
        w_writes   = 1'b1;
        w_fmt      = IMM_I;
      end
      OP: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        w_writes   = 1'b1;
      end
      BRANCH: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        w_fmt      = IMM_B;
      end
      STORE: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        w_fmt      = IMM_S;
      end
      FENCE, SYSTEM: begin
        w_fmt = IMM_I;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_rd    = i_instr[11:7];
  assign o_wreg  = w_writes & (i_instr[11:7] != 5'd0);
  assign o_imm   = build_imm(w_fmt, i_instr);

endmodule

// File: rtl/core_id_stage.sv
// Decode / operand-read stage: bypass network, hazard stall and ID/EX register.
module core_id_stage
  import core_pkg::*;
#(
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            ex_fwd_valid,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_wreg,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_fwd_valid,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_wreg,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_wreg,
  output logic            ex_is_load,
  output logic            ex_illegal
);

  localparam logic [XLEN-1:0] LP_PC_RST = 32'(RESET_PC_UNUSED);

  logic            w_rs1_used, w_rs2_used, w_wreg, w_is_load, w_illegal;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_rd;

  logic [1:0][4:0]      w_src_addr;
  logic [1:0]           w_src_used;
  logic [1:0][XLEN-1:0] w_src_rf;
  logic [1:0][XLEN-1:0] w_src_data;
  logic [1:0]           w_src_stall;
  logic                 w_stall, w_advance, w_capture;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rd_addr;
  logic            r_wreg, r_is_load, r_illegal;

  core_decoder u_dec (
    .i_instr    (if_instr),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_wreg     (w_wreg),
    .o_is_load  (w_is_load),
    .o_illegal  (w_illegal),
    .o_imm      (w_imm),
    .o_rd       (w_rd)
  );

  assign rf_rs1_addr = if_instr[19:15];
  assign rf_rs2_addr = if_instr[24:20];

  assign w_src_addr = {rf_rs2_addr, rf_rs1_addr};
  assign w_src_used = {w_rs2_used, w_rs1_used};
  assign w_src_rf   = {rf_rs2_data, rf_rs1_data};

  // Per source: first matching producer wins; an unavailable EX/MEM match
  // stalls and is never bypassed by a lower-priority match.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_src_data[s]  = '0;
      w_src_stall[s] = 1'b0;
      if (w_src_addr[s] != 5'd0) begin
        if (r_valid && r_wreg && (r_rd_addr == w_src_addr[s])) begin
          w_src_data[s]  = ex_fwd_data;
          w_src_stall[s] = w_src_used[s] & ~ex_fwd_valid;
        end else if (mem_wreg && (mem_rd_addr == w_src_addr[s])) begin
          w_src_data[s]  = mem_fwd_data;
          w_src_stall[s] = w_src_used[s] & ~mem_fwd_valid;
        end else if (wb_wreg && (wb_rd_addr == w_src_addr[s])) begin
          w_src_data[s] = wb_rd_data;
        end else begin
          w_src_data[s] = w_src_rf[s];
        end
      end
    end
  end

  assign w_stall   = |w_src_stall;
  assign w_advance = ~r_valid | ex_ready;
  assign if_ready  = flush | (w_advance & ~w_stall);
  assign w_capture = if_valid & if_ready & ~flush;

  // ID/EX register: flush kills, capture loads, otherwise drain to a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= LP_PC_RST;
      r_instr    <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd_addr  <= '0;
      r_wreg     <= 1'b0;
      r_is_load  <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_pc       <= if_pc;
      r_instr    <= if_instr;
      r_rs1_data <= w_src_data[0];
      r_rs2_data <= w_src_data[1];
      r_imm      <= w_imm;
      r_rd_addr  <= w_rd;
      r_wreg     <= w_wreg;
      r_is_load  <= w_is_load;
      r_illegal  <= w_illegal;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_instr    = r_instr;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rd_addr  = r_rd_addr;
  assign ex_wreg     = r_wreg;
  assign ex_is_load  = r_is_load;
  assign ex_illegal  = r_illegal;

endmodule

// File: tb/tb_core_id_stage.sv
// Directed bench for core_id_stage with a behavioural reference model.
module tb_core_id_stage;

  logic        clk, rst;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        ex_fwd_valid;
  logic [31:0] ex_fwd_data;
  logic        mem_wreg, mem_fwd_valid;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_wreg;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd_addr;
  logic        ex_wreg, ex_is_load, ex_illegal;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_errors = 0;

  core_id_stage #(.RESET_PC_UNUSED(0)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_data(ex_fwd_data),
    .mem_wreg(mem_wreg), .mem_rd_addr(mem_rd_addr),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_data(mem_fwd_data),
    .wb_wreg(wb_wreg), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd_addr(ex_rd_addr), .ex_wreg(ex_wreg),
    .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
  assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] pc, instr, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wreg, ld, ill, u1, u2;
  } ent_t;

  ent_t m;

  function automatic ent_t tb_decode(logic [31:0] pc, logic [31:0] ins);
    ent_t        e  = '0;
    logic [31:0] sx = 32'($signed(ins) >>> 20);
    logic        wr = 1'b0;
    e.pc    = pc;
    e.instr = ins;
    e.rd    = ins[11:7];
    case (ins[6:0])
      7'h37, 7'h17: begin wr = 1'b1; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin wr = 1'b1; e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h67, 7'h13: begin wr = 1'b1; e.u1 = 1'b1; e.imm = sx; end
      7'h03: begin wr = 1'b1; e.u1 = 1'b1; e.ld = 1'b1; e.imm = sx; end
      7'h33: begin wr = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1; e.imm = 32'd0; end
      7'h63: begin e.u1 = 1'b1; e.u2 = 1'b1; e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h23: begin e.u1 = 1'b1; e.u2 = 1'b1; e.imm = (sx & ~32'h1F) | {27'd0, ins[11:7]}; end
      7'h0F, 7'h73: e.imm = sx;
      default: e.ill = 1'b1;
    endcase
    e.wreg = wr && (ins[11:7] != 5'd0);
    return e;
  endfunction

  // {unavailable, value} for register a, walking producers youngest first.
  function automatic logic [32:0] tb_resolve(logic [4:0] a);
    logic        hit [4];
    logic        ok  [4];
    logic [31:0] d   [4];
    if (a == 5'd0) return 33'd0;
    hit[0] = m.v && m.wreg && (m.rd == a); ok[0] = ex_fwd_valid;  d[0] = ex_fwd_data;
    hit[1] = mem_wreg && (mem_rd_addr == a); ok[1] = mem_fwd_valid; d[1] = mem_fwd_data;
    hit[2] = wb_wreg && (wb_rd_addr == a);   ok[2] = 1'b1;          d[2] = wb_rd_data;
    hit[3] = 1'b1;                           ok[3] = 1'b1;          d[3] = rf[a];
    for (int i = 0; i < 4; i++)
      if (hit[i]) return {~ok[i], ok[i] ? d[i] : 32'd0};
    return 33'd0;
  endfunction

  function automatic logic tb_if_ready();
    ent_t        e  = tb_decode(if_pc, if_instr);
    logic [32:0] r1 = tb_resolve(if_instr[19:15]);
    logic [32:0] r2 = tb_resolve(if_instr[24:20]);
    logic        st = (e.u1 && r1[32]) || (e.u2 && r2[32]);
    return flush || ((!m.v || ex_ready) && !st);
  endfunction

  function automatic ent_t tb_capture();
    ent_t        e  = tb_decode(if_pc, if_instr);
    logic [32:0] r1 = tb_resolve(if_instr[19:15]);
    logic [32:0] r2 = tb_resolve(if_instr[24:20]);
    e.rs1 = r1[31:0];
    e.rs2 = r2[31:0];
    e.v   = 1'b1;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                             m   <= '0;
    else if (flush)                      m.v <= 1'b0;
    else if (if_valid && tb_if_ready())  m   <= tb_capture();
    else if (!m.v || ex_ready)           m.v <= 1'b0;
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("if_ready", 32'(if_ready), 32'(tb_if_ready()));
    chk("ex_valid", 32'(ex_valid), 32'(m.v));
    if (m.v || rst) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_instr", ex_instr, m.instr);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rd_addr", 32'(ex_rd_addr), 32'(m.rd));
      chk("ex_wreg", 32'(ex_wreg), 32'(m.wreg));
      chk("ex_is_load", 32'(ex_is_load), 32'(m.ld));
      chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
      if (m.u1 || rst) chk("ex_rs1_data", ex_rs1_data, m.rs1);
      if (m.u2 || rst) chk("ex_rs2_data", ex_rs2_data, m.rs2);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] imm;
    logic        wreg;
    logic        ill;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'hFFF00093, 32'hFFFF_FFFF, 1'b1, 1'b0};  // addi x1,x0,-1
    vecs[1] = '{32'h123451B7, 32'h1234_5000, 1'b1, 1'b0};  // lui x3,0x12345
    vecs[2] = '{32'hFE208EE3, 32'hFFFF_FFFC, 1'b0, 1'b0};  // beq x1,x2,-4
    vecs[3] = '{32'h00000013, 32'h0000_0000, 1'b0, 1'b0};  // addi x0,x0,0
    vecs[4] = '{32'h00000000, 32'h0000_0000, 1'b0, 1'b1};  // illegal
    vecs[5] = '{32'h008000EF, 32'h0000_0008, 1'b1, 1'b0};  // jal x1,+8

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    ex_fwd_valid = 1'b0; ex_fwd_data = '0;
    mem_wreg = 1'b0; mem_rd_addr = '0; mem_fwd_valid = 1'b0; mem_fwd_data = '0;
    wb_wreg = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("post_reset if_ready", 32'(if_ready), 32'd1);
    chk("post_reset ex_valid", 32'(ex_valid), 32'd0);

    // ADDI x5,x0,7
    if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h00700293;
    cyc();
    chk("addi ex_valid", 32'(ex_valid), 32'd1);
    chk("addi rd", 32'(ex_rd_addr), 32'd5);
    chk("addi imm", ex_imm, 32'd7);
    chk("addi wreg", 32'(ex_wreg), 32'd1);
    chk("addi rs1", ex_rs1_data, 32'd0);

    // Bypass priority with x5 in EX, MEM and WB: ADD x6,x5,x5
    if_pc = 32'h104; if_instr = 32'h00528333;
    wb_wreg = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h11;
    mem_wreg = 1'b1; mem_rd_addr = 5'd5; mem_fwd_valid = 1'b1; mem_fwd_data = 32'h22;
    ex_fwd_valid = 1'b0; ex_fwd_data = 32'h33;
    #1;
    chk("ex_pending stall if_ready", 32'(if_ready), 32'd0);
    ex_fwd_valid = 1'b1;
    #1;
    chk("ex_fwd if_ready", 32'(if_ready), 32'd1);
    cyc();
    chk("bypass rs1", ex_rs1_data, 32'h33);
    chk("bypass rs2", ex_rs2_data, 32'h33);
    chk("bypass rd", 32'(ex_rd_addr), 32'd6);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x0
    mem_wreg = 1'b0; wb_wreg = 1'b0; ex_fwd_valid = 1'b0;
    if_pc = 32'h108; if_instr = 32'h0000A283;
    cyc();
    chk("lw is_load", 32'(ex_is_load), 32'd1);
    chk("lw rs1", ex_rs1_data, 32'h1001);
    if_pc = 32'h10C; if_instr = 32'h00028333;
    #1;
    chk("load_use if_ready", 32'(if_ready), 32'd0);
    cyc();
    chk("load_use bubble", 32'(ex_valid), 32'd0);
    mem_wreg = 1'b1; mem_rd_addr = 5'd5; mem_fwd_valid = 1'b1; mem_fwd_data = 32'h44;
    #1;
    chk("mem_ready if_ready", 32'(if_ready), 32'd1);
    cyc();
    chk("load_use ex_valid", 32'(ex_valid), 32'd1);
    chk("load_use rs1", ex_rs1_data, 32'h44);
    chk("load_use pc", ex_pc, 32'h10C);

    // Backpressure for 3 cycles, then SW x5,8(x2)
    mem_wreg = 1'b0; ex_ready = 1'b0;
    if_pc = 32'h110; if_instr = 32'h00512423;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp if_ready", 32'(if_ready), 32'd0);
      chk("bp ex_valid", 32'(ex_valid), 32'd1);
      chk("bp ex_pc", ex_pc, 32'h10C);
      chk("bp ex_instr", ex_instr, 32'h00028333);
      chk("bp ex_rs1", ex_rs1_data, 32'h44);
      cyc();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp release if_ready", 32'(if_ready), 32'd1);
    cyc();
    chk("sw pc", ex_pc, 32'h110);
    chk("sw imm", ex_imm, 32'd8);
    chk("sw rs1", ex_rs1_data, 32'h1002);
    chk("sw rs2", ex_rs2_data, 32'h1005);
    chk("sw wreg", 32'(ex_wreg), 32'd0);

    // Flush during a MEM-pending stall
    mem_wreg = 1'b1; mem_rd_addr = 5'd5; mem_fwd_valid = 1'b0;
    if_pc = 32'h114; if_instr = 32'h00528333;
    #1;
    chk("mem_pending if_ready", 32'(if_ready), 32'd0);
    flush = 1'b1;
    #1;
    chk("flush if_ready", 32'(if_ready), 32'd1);
    cyc();
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; mem_wreg = 1'b0;

    // x0 never takes bypass data: ADD x7,x0,x0 with WB writing x0
    wb_wreg = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'hFF;
    if_pc = 32'h118; if_instr = 32'h000003B3;
    cyc();
    chk("x0 rs1", ex_rs1_data, 32'd0);
    chk("x0 rs2", ex_rs2_data, 32'd0);
    chk("x0 rd", 32'(ex_rd_addr), 32'd7);
    wb_wreg = 1'b0;

    // Immediate formats, rd=x0 and illegal opcode
    for (int i = 0; i < 6; i++) begin
      if_pc = 32'h200 + 32'(i * 4); if_instr = vecs[i].ins;
      cyc();
      chk("vec ex_valid", 32'(ex_valid), 32'd1);
      chk("vec imm", ex_imm, vecs[i].imm);
      chk("vec wreg", 32'(ex_wreg), 32'(vecs[i].wreg));
      chk("vec illegal", 32'(ex_illegal), 32'(vecs[i].ill));
    end

    // Asynchronous reset with an instruction held in ID/EX
    #2;
    rst = 1'b1;
    #1;
    chk("async ex_valid", 32'(ex_valid), 32'd0);
    chk("async ex_pc", ex_pc, 32'd0);
    chk("async ex_instr", ex_instr, 32'd0);
    chk("async ex_imm", ex_imm, 32'd0);
    chk("async ex_rd", 32'(ex_rd_addr), 32'd0);
    chk("async ex_wreg", 32'(ex_wreg), 32'd0);
    if_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("release if_ready", 32'(if_ready), 32'd1);
    cyc();
    chk("idle ex_valid", 32'(ex_valid), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
